// File: rtl/lfsr_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_burst_ctrl
// Purpose  : Command-driven burst sequencer around an 8-bit XNOR LFSR
//            (taps 7 and 3, shift toward MSB, feedback into bit 0). A command
//            optionally seeds the LFSR and sets a beat count; the block then
//            streams that many pseudo-random bytes over valid/ready and
//            reports completion or abort with a one-cycle done pulse.
// Ports    : clk, reset (sync, active-low)
//            cmd_valid/cmd_ready, cmd_load_seed, cmd_seed[7:0],
//            cmd_len[LEN_W-1:0]     - command channel
//            abort                  - terminate a running burst
//            out_valid/out_ready, out_data[7:0], out_last - beat stream
//            busy, done, done_aborted, seed_err, lfsr_state[7:0] - status
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_burst_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_load_seed,
  input  logic [7:0]       cmd_seed,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             done_aborted,
  output logic             seed_err,
  output logic [7:0]       lfsr_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0]       LOCKUP  = 8'hFF;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;

  state_t           state_q, state_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             aborted_q, aborted_d;
  logic             seed_err_q, seed_err_d;
  logic [7:0]       lfsr_step;
  logic             last_beat;

  // XNOR feedback keeps 8'h00 a legal state; 8'hFF is the lock-up value.
  assign lfsr_step = {lfsr_q[6:0], ~(lfsr_q[7] ^ lfsr_q[3])};
  assign last_beat = (rem_q == LEN_ONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      lfsr_q     <= 8'h00;
      rem_q      <= '0;
      aborted_q  <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      rem_q      <= rem_d;
      aborted_q  <= aborted_d;
      seed_err_q <= seed_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lfsr_d       = lfsr_q;
    rem_d        = rem_q;
    aborted_d    = aborted_q;
    seed_err_d   = 1'b0;
    cmd_ready    = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    done         = 1'b0;
    done_aborted = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_load_seed) begin
            // A lock-up seed would freeze the sequence; substitute 8'h00.
            if (cmd_seed == LOCKUP) begin
              lfsr_d     = 8'h00;
              seed_err_d = 1'b1;
            end else begin
              lfsr_d = cmd_seed;
            end
          end
          rem_d     = cmd_len;
          aborted_d = 1'b0;
          state_d   = (cmd_len != LEN_ZERO) ? S_RUN : S_DONE;
        end
      end

      S_RUN: begin
        out_valid = 1'b1;
        out_last  = last_beat;
        if (out_ready) begin
          // A beat handshaken in the abort cycle still counts.
          lfsr_d = lfsr_step;
          if (rem_q != LEN_ZERO) begin
            rem_d = rem_q - LEN_ONE;
          end
          if (last_beat) begin
            state_d   = S_DONE;
            aborted_d = 1'b0;
          end else if (abort) begin
            state_d   = S_DONE;
            aborted_d = 1'b1;
          end
        end else if (abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end
      end

      S_DONE: begin
        done         = 1'b1;
        done_aborted = aborted_q;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_data   = lfsr_q;
  assign lfsr_state = lfsr_q;
  assign busy       = (state_q != S_IDLE);
  assign seed_err   = seed_err_q;

endmodule
`default_nettype wire

// File: doc/lfsr_burst_ctrl.md
Name: lfsr_burst_ctrl

Overview:
Command-driven sequencer around an 8-bit XNOR LFSR (taps 7 and 3, shift toward MSB, feedback into bit 0). It accepts a burst command with an optional seed load and a beat count, then streams that many pseudo-random bytes over a valid/ready interface. It reports completion or abort. It sits between a host or test controller and any pattern consumer, such as a BIST or scrambler datapath.

Parameters:
LEN_W, 8, width of burst length field and internal remaining-beat counter.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous reset, active-low (reset==0 resets on next rising clk edge)
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept command
cmd_load_seed  in  1  1: load cmd_seed into LFSR before burst; 0: continue from current LFSR state
cmd_seed  in  8  seed value
cmd_len  in  LEN_W  number of beats in burst
abort  in  1  terminate running burst
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts beat
out_data  out  8  current LFSR value
out_last  out  1  final beat of burst (qualified by out_valid)
busy  out  1  state != IDLE
done  out  1  one-cycle completion pulse
done_aborted  out  1  with done: burst ended by abort
seed_err  out  1  one-cycle pulse: lock-up seed 8'hFF was replaced
lfsr_state  out  8  live LFSR register

Behaviour:
- LFSR next value = {lfsr[6:0], ~(lfsr[7] ^ lfsr[3])}. 8'hFF is the lock-up state and is never entered.
- Reset (reset==0 at clk edge):
  - state=IDLE; lfsr=8'h00; remaining=0.
  - All outputs 0, except cmd_ready=1 once state is IDLE.
  - Reset overrides everything, including mid-burst; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready:
    - If cmd_load_seed: lfsr<=cmd_seed. If cmd_seed==8'hFF, lfsr<=8'h00 instead and seed_err pulses in the following cycle.
    - remaining<=cmd_len.
    - Next state = RUN if cmd_len!=0, else DONE (zero-length burst: no beats).
  - abort is ignored in IDLE.
- RUN:
  - out_valid=1, out_data=lfsr, out_last=(remaining==1).
  - On out_valid&&out_ready: lfsr advances one step; remaining decrements. If the beat was the last one, next state = DONE.
  - Without out_ready: out_data, out_last and lfsr hold stable (AXI-style; valid is never withdrawn except by abort or reset).
  - abort==1 in RUN: next state = DONE with done_aborted=1; no further beats; lfsr holds its value.
    - If abort and a handshake coincide, the handshaken beat counts and lfsr advances, then abort wins.
    - If that beat was the last, done_aborted=0 (the burst completed normally).
  - cmd_ready=0; commands are not queued.
- DONE:
  - done=1 for exactly one cycle; done_aborted valid in the same cycle.
  - Next state = IDLE. cmd_ready=0 in DONE, so the earliest next command is accepted one cycle later.
- Latency: command accept to first out_valid is 1 cycle. With out_ready held high, last beat to done is 1 cycle.
- Counter: remaining is LEN_W bits; the maximum burst is 2^LEN_W-1 beats. No wrap: the counter never decrements below 0.
- The LFSR state persists across bursts, so cmd_load_seed=0 continues the sequence.
- busy=1 in RUN and DONE.
- Reference sequence from 8'h00: 00,01,03,07,0F,1E,3C,78,F0,E0.

Test Plan:
- Reset, then cmd seed=8'h00 load=1 len=10, out_ready=1 → out_data 00,01,03,07,0F,1E,3C,78,F0,E0 on consecutive cycles; out_last only on E0; done pulse 1 cycle after the E0 beat, done_aborted=0.
- Same command with out_ready toggling 1/0 every cycle → identical data order; out_data stable during stalls; 10 handshakes total.
- cmd seed=8'hFF load=1 len=3 → seed_err pulses once; beats 00,01,03.
- Burst len=4 from 00, then load=0 len=2 → second burst emits 0F,1E.
- len=5, abort on 3rd beat with out_ready=1 → beats 00,01,03 seen; done with done_aborted=1; lfsr_state=07.
- reset=0 mid-RUN, with out_ready=0 until then → next cycle out_valid=0, busy=0, lfsr_state=00, no done pulse; len=0 command afterwards → done pulse with no out_valid.
